// File: rtl/pix_buf_pingpong.sv
// Ping-pong RGB pixel buffer: writes fill one bank while reads drain the other.
// Define PIXBUF_CLEAR_EN to refill the new write bank with CLEAR_PIX after each swap.
module pix_buf_pingpong #(
   parameter int unsigned           CH_W      = 8,
   parameter int unsigned           DEPTH     = 10000,
   parameter int unsigned           ADDR_W    = 20,
   parameter logic [3*CH_W-1:0]     CLEAR_PIX = '1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              swap_req,
   output logic [CH_W-1:0]   r,
   output logic [CH_W-1:0]   g,
   output logic [CH_W-1:0]   b,
   output logic              rvalid,
   output logic              swap_ack,
   output logic              wr_bank,
   output logic              busy,
   output logic              err
);

   localparam int unsigned       PIX_W   = 3 * CH_W;
   localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_SWAP_PEND = 2'd1;
`ifdef PIXBUF_CLEAR_EN
   localparam logic [1:0] ST_CLEAR     = 2'd2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
`endif

   logic [1:0]       state_q, state_d;
   logic             wr_bank_q, wr_bank_d;
   logic [CH_W-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
   logic             rvalid_q, rvalid_d;
   logic             swap_ack_q, swap_ack_d;
   logic             err_q, err_d;
`ifdef PIXBUF_CLEAR_EN
   logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

   logic [PIX_W-1:0] mem_q [2][DEPTH];
   logic             mem_we;
   logic [IDX_W-1:0] mem_idx;
   logic [PIX_W-1:0] mem_wdat;
   logic [PIX_W-1:0] rd_pix;
   logic             wr_in_range, rd_in_range, writes_open;

   generate
      if (PIX_W < 32) begin : g_wdata_pad
         logic wdata_unused;
         assign wdata_unused = ^wdata[31:PIX_W];
      end
   endgenerate

   always_comb begin
      wr_in_range = (waddr < DEPTH_A);
      rd_in_range = (raddr < DEPTH_A);
      rd_pix      = rd_in_range ? mem_q[~wr_bank_q][raddr[IDX_W-1:0]] : '0;
`ifdef PIXBUF_CLEAR_EN
      writes_open = (state_q != ST_CLEAR);
`else
      writes_open = 1'b1;
`endif

      state_d    = state_q;
      wr_bank_d  = wr_bank_q;
      swap_ack_d = 1'b0;
      err_d      = err_q;
      rvalid_d   = re;
      r_d        = r_q;
      g_d        = g_q;
      b_d        = b_q;
      mem_we     = 1'b0;
      mem_idx    = waddr[IDX_W-1:0];
      mem_wdat   = CLEAR_PIX;
`ifdef PIXBUF_CLEAR_EN
      clr_cnt_d  = clr_cnt_q;
`endif

      if (re) begin
         {b_d, g_d, r_d} = rd_pix;
         if (!rd_in_range) err_d = 1'b1;
      end

      if (we) begin
         if (wr_in_range && writes_open) begin
            mem_we   = 1'b1;
            mem_wdat = wdata[PIX_W-1:0];
         end else begin
            err_d = 1'b1;
         end
      end

      // The swap waits for a quiet edge, so any coincident access still sees the old banks.
      case (state_q)
         ST_IDLE: begin
            if (swap_req) state_d = ST_SWAP_PEND;
         end
         ST_SWAP_PEND: begin
            if (!we && !re) begin
               wr_bank_d  = ~wr_bank_q;
               swap_ack_d = 1'b1;
`ifdef PIXBUF_CLEAR_EN
               state_d    = ST_CLEAR;
`else
               state_d    = ST_IDLE;
`endif
            end
         end
`ifdef PIXBUF_CLEAR_EN
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_idx   = clr_cnt_q;
            mem_wdat  = CLEAR_PIX;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_IDX) begin
               clr_cnt_d = '0;
               state_d   = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         wr_bank_q  <= 1'b0;
         r_q        <= '0;
         g_q        <= '0;
         b_q        <= '0;
         rvalid_q   <= 1'b0;
         swap_ack_q <= 1'b0;
         err_q      <= 1'b0;
`ifdef PIXBUF_CLEAR_EN
         clr_cnt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         wr_bank_q  <= wr_bank_d;
         r_q        <= r_d;
         g_q        <= g_d;
         b_q        <= b_d;
         rvalid_q   <= rvalid_d;
         swap_ack_q <= swap_ack_d;
         err_q      <= err_d;
`ifdef PIXBUF_CLEAR_EN
         clr_cnt_q  <= clr_cnt_d;
`endif
      end
   end

   // Bank storage is deliberately outside reset so contents survive it.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_bank_q][mem_idx] <= mem_wdat;
   end

   assign r        = r_q;
   assign g        = g_q;
   assign b        = b_q;
   assign rvalid   = rvalid_q;
   assign swap_ack = swap_ack_q;
   assign wr_bank  = wr_bank_q;
   assign busy     = (state_q != ST_IDLE);
   assign err      = err_q;

endmodule

// File: tb/tb_pix_buf_pingpong.sv
// Bench for pix_buf_pingpong: bank-level reference model compared every cycle,
// plus hand-computed directed checks. Honours PIXBUF_CLEAR_EN like the design.
module tb_pix_buf_pingpong;

   localparam int          CH_W      = 8;
   localparam int          DEPTH     = 256;
   localparam int          ADDR_W    = 20;
   localparam logic [23:0] CLEAR_PIX = 24'hFFFFFF;

   logic              clk, reset;
   logic              we, re, swap_req;
   logic [ADDR_W-1:0] waddr, raddr;
   logic [31:0]       wdata;
   logic [CH_W-1:0]   r, g, b;
   logic              rvalid, swap_ack, wr_bank, busy, err;

   pix_buf_pingpong #(
      .CH_W(CH_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_PIX(CLEAR_PIX)
   ) dut (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .swap_req(swap_req),
      .r(r), .g(g), .b(b), .rvalid(rvalid), .swap_ack(swap_ack),
      .wr_bank(wr_bank), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int ack_cnt  = 0;
   bit chk_en   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: two banks, a pending-swap flag and a remaining-clear count.
   logic [23:0]     m_mem [2][DEPTH];
   logic            m_bank, m_pend;
   int              m_left;
   logic [CH_W-1:0] exp_r, exp_g, exp_b;
   logic            exp_rvalid, exp_ack, exp_err;
   logic [23:0]     m_pix;
   int              m_ri, m_wi;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_bank = 0; m_pend = 0; m_left = 0;
         exp_r = 0; exp_g = 0; exp_b = 0;
         exp_rvalid = 0; exp_ack = 0; exp_err = 0;
      end else begin
         m_ri = int'(raddr);
         m_wi = int'(waddr);
         exp_ack = 0;
         if (re) begin
            exp_rvalid = 1;
            if (m_ri < DEPTH) m_pix = m_mem[!m_bank][m_ri];
            else begin m_pix = 0; exp_err = 1; end
            exp_r = m_pix[7:0]; exp_g = m_pix[15:8]; exp_b = m_pix[23:16];
         end else exp_rvalid = 0;
         if (we) begin
            if (m_wi >= DEPTH || m_left > 0) exp_err = 1;
            else m_mem[m_bank][m_wi] = wdata[23:0];
         end
         if (m_left > 0) begin
            m_mem[m_bank][DEPTH - m_left] = CLEAR_PIX;
            m_left--;
         end else if (m_pend) begin
            if (!we && !re) begin
               m_bank  = !m_bank;
               exp_ack = 1;
               m_pend  = 0;
`ifdef PIXBUF_CLEAR_EN
               m_left  = DEPTH;
`endif
            end
         end else if (swap_req) m_pend = 1;
      end
   end

   always @(negedge clk) begin
      if (reset && chk_en) begin
         check("r", r, exp_r);
         check("g", g, exp_g);
         check("b", b, exp_b);
         check("rvalid", rvalid, exp_rvalid);
         check("swap_ack", swap_ack, exp_ack);
         check("wr_bank", wr_bank, m_bank);
         check("busy", busy, m_pend || (m_left > 0));
         check("err", err, exp_err);
      end
   end

   always @(negedge clk) if (reset && swap_ack === 1'b1) ack_cnt++;

   task automatic drive(input logic w, input int wa, input logic [31:0] wd,
                        input logic rd, input int ra, input logic sw);
      @(negedge clk);
      we = w; waddr = wa[ADDR_W-1:0]; wdata = wd;
      re = rd; raddr = ra[ADDR_W-1:0]; swap_req = sw;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic rd(input int a);
      drive(0, 0, 0, 1, a, 0);
   endtask

   task automatic wait_quiet();
      int n = 0;
      while ((m_pend || m_left > 0) && n < DEPTH + 20) begin
         idle();
         n++;
      end
      check("wait_bound", n < DEPTH + 20, 1);
   endtask

   task automatic do_swap();
      drive(0, 0, 0, 0, 0, 1);
      idle();
   endtask

   initial begin
      int a0, n;
      reset = 0; we = 0; re = 0; swap_req = 0; waddr = 0; raddr = 0; wdata = 0;
      repeat (3) @(negedge clk);
      check("rst_r", r, 0);  check("rst_g", g, 0);  check("rst_b", b, 0);
      check("rst_rvalid", rvalid, 0); check("rst_ack", swap_ack, 0);
      check("rst_bank", wr_bank, 0);  check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      @(negedge clk); #1 reset = 1; chk_en = 1;

      // Make both banks fully known.
      for (int a = 0; a < DEPTH; a++) drive(1, a, 32'h00100000 + 32'(a * 3), 0, 0, 0);
      do_swap(); wait_quiet();
      for (int a = 0; a < DEPTH; a++) drive(1, a, 32'h00200000 + 32'(a * 5), 0, 0, 0);
      do_swap(); wait_quiet();
      check("init_bank", wr_bank, 0);

      // Write, swap, read back split channels; then rvalid drops and data holds.
      drive(1, 5, 32'h00A1B2C3, 0, 0, 0);
      do_swap();
      rd(5);
      idle();
      check("rd5_r", r, 8'hC3); check("rd5_g", g, 8'hB2); check("rd5_b", b, 8'hA1);
      check("rd5_rvalid", rvalid, 1);
      idle();
      check("hold_rvalid", rvalid, 0); check("hold_r", r, 8'hC3);
      wait_quiet();

      // Swap requested under a 3-cycle write burst.
      a0 = ack_cnt;
      drive(1, 10, 32'hFF112233, 0, 0, 1);
      drive(1, 11, 32'h00445566, 0, 0, 0);
      drive(1, 12, 32'h00778899, 0, 0, 0);
      idle();
      idle();
      check("burst_ack", swap_ack, 1); check("burst_bank", wr_bank, 0);
      idle();
      check("burst_ack_off", swap_ack, 0);
      wait_quiet();
      check("burst_ack_cnt", ack_cnt - a0, 1);
      rd(10); rd(11);
      check("old10", {b, g, r}, 24'h112233);
      rd(12);
      check("old11", {b, g, r}, 24'h445566);
      idle();
      check("old12", {b, g, r}, 24'h778899);

      // Second swap_req while pending.
      a0 = ack_cnt;
      drive(1, 20, 32'h00010203, 0, 0, 1);
      drive(1, 21, 32'h00040506, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);
      repeat (4) idle();
      wait_quiet();
      repeat (2) idle();
      check("dbl_ack_cnt", ack_cnt - a0, 1);
      check("dbl_bank", wr_bank, 1);

`ifdef PIXBUF_CLEAR_EN
      // Clear duration, dropped write, and fully cleared bank after next swap.
      do_swap();
      n = 0;
      for (int k = 0; k < DEPTH + 10; k++) begin
         if (k == 5) drive(1, 7, 32'h00ABCDEF, 0, 0, 0);
         else idle();
         if (busy === 1'b1) n++;
         else break;
      end
      check("clr_busy_cycles", n, DEPTH);
      check("clr_drop_err", err, 1);
      check("clr_bank", wr_bank, 0);
      do_swap();
      for (int a = 0; a < DEPTH; a++) rd(a);
      rd(7);
      idle();
      check("clr_addr7", {b, g, r}, 24'hFFFFFF);
      wait_quiet();

      // Reset at clear count 100.
      drive(1, 99, 32'h00654321, 0, 0, 0);
      drive(1, 100, 32'h00123456, 0, 0, 0);
      do_swap(); wait_quiet();
      do_swap();
      repeat (101) idle();
      #1 reset = 0;
      #2;
      check("mid_r", r, 0); check("mid_rvalid", rvalid, 0);
      check("mid_bank", wr_bank, 0); check("mid_busy", busy, 0);
      check("mid_err", err, 0); check("mid_ack", swap_ack, 0);
      reset = 1;
      rd(99); rd(100);
      check("mid_addr99", {b, g, r}, 24'hFFFFFF);
      idle();
      check("mid_addr100", {b, g, r}, 24'h123456);
      repeat (3) idle();
      check("mid_idle", busy, 0);
`else
      // Reset pulse retains bank contents.
      idle();
      #1 reset = 0;
      #2;
      check("mid_r", r, 0); check("mid_rvalid", rvalid, 0);
      check("mid_bank", wr_bank, 0); check("mid_busy", busy, 0);
      check("mid_err", err, 0); check("mid_ack", swap_ack, 0);
      reset = 1;
      rd(10);
      idle();
      check("keep_addr10", {b, g, r}, 24'h112233);
`endif

      // Out-of-range read, err sticky.
      rd(DEPTH);
      idle();
      check("oor_rvalid", rvalid, 1);
      check("oor_pix", {b, g, r}, 0);
      check("oor_err", err, 1);
      repeat (3) idle();
      check("oor_err_sticky", err, 1);
      drive(1, DEPTH + 3, 32'h00FFFFFF, 0, 0, 0);
      repeat (2) idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
